// File: rtl/glm_vector_elementwise.sv
// glm_vector_elementwise: pops lines in lockstep from a left and a right FIFO,
// applies SUB / ADD / MUL / AXPY (signed Q16.16) lane by lane, and streams the
// result lines to a writer. It honours sink back-pressure and repeats the line
// sequence for a programmable number of passes.
// Optional feature macro: GLM_ELEMWISE_SATURATE_EN. When it is defined, each lane
// saturates and a sticky 'saturated' port is present. Otherwise results wrap
// modulo 2^VALUE_WIDTH.

module glm_vector_elementwise_lane #(
  parameter int VALUE_WIDTH = 32
) (
  input  logic [1:0]             mode,
  input  logic [VALUE_WIDTH-1:0] a,
  input  logic [VALUE_WIDTH-1:0] b,
  input  logic [VALUE_WIDTH-1:0] scale,
  output logic [VALUE_WIDTH-1:0] result
`ifdef GLM_ELEMWISE_SATURATE_EN
  ,
  output logic                   clip
`endif
);
  localparam int W    = VALUE_WIDTH;
  localparam int XW   = 2*W + 2;
  localparam int FRAC = 16;

  logic signed [W-1:0]   a_s, b_s, s_s;
  logic signed [2*W-1:0] prod_ab, prod_bs;
  logic signed [XW-1:0]  wide;

  assign a_s     = a;
  assign b_s     = b;
  assign s_s     = scale;
  assign prod_ab = (2*W)'(a_s) * (2*W)'(b_s);
  assign prod_bs = (2*W)'(b_s) * (2*W)'(s_s);

  // Exact lane result, held wide enough that no mode can overflow it.
  always_comb begin
    wide = '0;
    case (mode)
      2'd0:    wide = XW'(a_s) - XW'(b_s);
      2'd1:    wide = XW'(a_s) + XW'(b_s);
      2'd2:    wide = XW'(prod_ab) >>> FRAC;
      default: wide = XW'(a_s) - (XW'(prod_bs) >>> FRAC);
    endcase
  end

`ifdef GLM_ELEMWISE_SATURATE_EN
  // The value fits only if every bit above the result's sign bit matches it.
  logic fits;
  assign fits   = (wide[XW-1:W-1] == '0) || (wide[XW-1:W-1] == '1);
  assign clip   = !fits;
  assign result = fits ? wide[W-1:0]
                : (wide[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
  logic unused_hi;
  assign unused_hi = ^wide[XW-1:W];
  assign result    = wide[W-1:0];
`endif
endmodule

module glm_vector_elementwise #(
  parameter int VALUES_PER_LINE = 16,
  parameter int VALUE_WIDTH     = 32,
  parameter int LINE_WIDTH      = VALUES_PER_LINE*VALUE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  output logic                  op_done,
  output logic                  busy,
  input  logic [3:0][31:0]      regs,
  input  logic                  left_empty,
  input  logic                  right_empty,
  output logic                  left_re,
  output logic                  right_re,
  input  logic [LINE_WIDTH-1:0] left_rdata,
  input  logic [LINE_WIDTH-1:0] right_rdata,
  input  logic                  left_rvalid,
  input  logic                  right_rvalid,
  input  logic                  out_almostfull,
  output logic                  out_we,
  output logic [LINE_WIDTH-1:0] out_wdata
`ifdef GLM_ELEMWISE_SATURATE_EN
  ,
  output logic                  saturated
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic        accept, pop_next, re_q, line_valid;
  logic [31:0] total_in, total_q, issued, written;
  logic [15:0] lines_q, line_idx, pass_idx;
  logic [1:0]  mode_q;
  logic [31:0] scale_q;
  logic        unused_regs;

  logic [VALUES_PER_LINE-1:0][VALUE_WIDTH-1:0] lane_res;
`ifdef GLM_ELEMWISE_SATURATE_EN
  logic [VALUES_PER_LINE-1:0]                  lane_clip;
`endif

  assign total_in    = 32'(regs[0][15:0]) * 32'(regs[0][31:16]);
  assign unused_regs = ^{regs[3], regs[1][31:2]};
  assign busy        = (state_q != S_IDLE);
  assign left_re     = re_q;
  assign right_re    = re_q;
  assign line_valid  = left_rvalid & right_rvalid;

  // Next state, instruction accept and pop decision.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    pop_next = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A start that coincides with op_done belongs to the finishing op: drop it.
        if (op_start && !op_done) begin
          accept  = 1'b1;
          state_d = (total_in == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        pop_next = !left_empty && !right_empty && !out_almostfull && (issued < total_q);
        // Last pop has retired from re; its data is already on rvalid and
        // gets written unconditionally, so op_done lands the cycle after it.
        if ((issued == total_q) && !re_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Registered pop strobe and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_q    <= 1'b0;
      op_done <= 1'b0;
    end else begin
      re_q    <= pop_next;
      op_done <= (state_q == S_DONE);
    end
  end

  // Instruction latch and progress counters. 'issued' counts decided pops,
  // so it already includes the pop currently shown on re.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lines_q  <= '0;
      mode_q   <= '0;
      scale_q  <= '0;
      total_q  <= '0;
      issued   <= '0;
      written  <= '0;
      line_idx <= '0;
      pass_idx <= '0;
    end else if (accept) begin
      lines_q  <= regs[0][15:0];
      mode_q   <= regs[1][1:0];
      scale_q  <= regs[2];
      total_q  <= total_in;
      issued   <= '0;
      written  <= '0;
      line_idx <= '0;
      pass_idx <= '0;
    end else begin
      if (pop_next) issued <= issued + 32'd1;
      if (out_we)   written <= written + 32'd1;
      if (re_q) begin
        if (line_idx == lines_q - 16'd1) begin
          line_idx <= '0;
          pass_idx <= pass_idx + 16'd1;
        end else begin
          line_idx <= line_idx + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < VALUES_PER_LINE; i++) begin : g_lane
    glm_vector_elementwise_lane #(.VALUE_WIDTH(VALUE_WIDTH)) u_lane (
      .mode   (mode_q),
      .a      (left_rdata[i*VALUE_WIDTH +: VALUE_WIDTH]),
      .b      (right_rdata[i*VALUE_WIDTH +: VALUE_WIDTH]),
      .scale  (scale_q[VALUE_WIDTH-1:0]),
      .result (lane_res[i])
`ifdef GLM_ELEMWISE_SATURATE_EN
      ,
      .clip   (lane_clip[i])
`endif
    );
  end

  // Output register: one result line per valid source line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_we    <= 1'b0;
      out_wdata <= '0;
    end else begin
      out_we <= line_valid;
      if (line_valid) out_wdata <= lane_res;
    end
  end

`ifdef GLM_ELEMWISE_SATURATE_EN
  // Sticky clip flag for the current instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        saturated <= 1'b0;
    else if (accept)                  saturated <= 1'b0;
    else if (line_valid && |lane_clip) saturated <= 1'b1;
  end
`endif
endmodule
